// File: rtl/platform_pkg.sv
// Platform-wide constants shared by peripheral blocks.
package platform_pkg;
  // Clock cycles per UART bit at the platform's default clock and baud rate.
  localparam int CLKS_PER_BAUD = 868;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: combinational read of the head entry, registered count.
// push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; entries only matter once written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. Frames go out back to back
// while the FIFO holds data; the line idles high otherwise.
module uart_tx_fifo
  import platform_pkg::*;
#(
  parameter int CLKS_PER_BAUD = platform_pkg::CLKS_PER_BAUD,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int CW = (CLKS_PER_BAUD > 2) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n;
  logic          pop;
  logic          full, empty;
  logic [7:0]    head;

  assign ready_o = !full;
  assign busy_o  = (state != IDLE) || (fifo_count_o != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (valid_i && ready_o),
    .din    (data_i),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count_o)
  );

  // State and datapath registers; the line output is registered here too.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      sh        <= sh_n;
      uart_tx_o <= tx_n;
    end
  end

  // Next-state logic. The shift register is consumed LSB first: each bit
  // transition drives sh[0] onto the line and shifts right.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    tx_n      = uart_tx_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = head;
          cnt_n   = CNT_TOP;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n     = CNT_TOP;
          bit_idx_n = '0;
          tx_n      = sh[0];
          sh_n      = {1'b0, sh[7:1]};
          state_n   = DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = CNT_TOP;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = sh[0];
            sh_n      = {1'b0, sh[7:1]};
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            sh_n    = head;
            cnt_n   = CNT_TOP;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o, uart_tx_o, busy_o;
  logic [2:0] fifo_count_o;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BAUD(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected line level at offset o (0..39) into the frame of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int o);
    if (o < 4)       return 1'b0;
    else if (o < 36) return b[(o - 4) / 4];
    else             return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; valid_i = 1'b0;
    repeat (3) step();
    checks++;
    if (uart_tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: tx=%b ready=%b busy=%b count=%0d, want tx=1 ready=1 busy=0 count=0",
               uart_tx_o, ready_o, busy_o, fifo_count_o);
    end
    rstn_i = 1'b1;
    step();
    checks++;
    if (uart_tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b, want 1 1 0", uart_tx_o, ready_o, busy_o);
    end
  endtask

  // Single byte: k counts edges after the accepting edge E.
  task automatic test_single();
    data_i = 8'h55; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++;
    if (uart_tx_o !== 1'b1 || fifo_count_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: tx=%b count=%0d busy=%b, want 1 1 1", uart_tx_o, fifo_count_o, busy_o);
    end
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k <= 40) begin
        checks++;
        if (uart_tx_o !== exp_bit(8'h55, k - 1)) begin
          errors++;
          $display("FAIL single_line k=%0d: tx=%b want %b", k, uart_tx_o, exp_bit(8'h55, k - 1));
        end
      end
      if (k == 40) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_e40: busy=%b want 1", busy_o);
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
      errors++;
      $display("FAIL single_done_e41: busy=%b tx=%b want 0 1", busy_o, uart_tx_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [2];
    b[0] = 8'hA5; b[1] = 8'h3C;
    data_i = b[0]; valid_i = 1'b1;
    step();
    data_i = b[1];
    step();
    valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 3'd1) begin
      errors++;
      $display("FAIL b2b_count_e1: count=%0d want 1", fifo_count_o);
    end
    checks++;
    if (uart_tx_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_e1: tx=%b want 0", uart_tx_o);
    end
    for (int k = 2; k <= 81; k++) begin
      step();
      if (k <= 80) begin
        checks++;
        if (uart_tx_o !== exp_bit(b[(k - 1) / 40], (k - 1) % 40)) begin
          errors++;
          $display("FAIL b2b_line k=%0d: tx=%b want %b", k, uart_tx_o,
                   exp_bit(b[(k - 1) / 40], (k - 1) % 40));
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: busy=%b tx=%b want 0 1", busy_o, uart_tx_o);
    end
  endtask

  // Stream 0..5 with valid held high; data is garbage whenever ready is low.
  task automatic test_flow();
    int idx = 0;
    logic rdy;
    data_i = 8'h00; valid_i = 1'b1;
    for (int c = 0; c <= 241; c++) begin
      rdy = ready_o;
      step();
      if (idx < 6 && rdy) idx++;
      valid_i = (idx < 6);
      data_i  = (idx < 6 && ready_o) ? 8'(idx) : 8'hEE;
      if (c >= 1 && c <= 240) begin
        checks++;
        if (uart_tx_o !== exp_bit(8'((c - 1) / 40), (c - 1) % 40)) begin
          errors++;
          $display("FAIL flow_line c=%0d: tx=%b want %b", c, uart_tx_o,
                   exp_bit(8'((c - 1) / 40), (c - 1) % 40));
        end
      end
      if (c == 3 || c == 4 || c == 40 || c == 41 || c == 42) begin
        checks++;
        if (c == 3 && (fifo_count_o !== 3'd3 || ready_o !== 1'b1)) begin
          errors++;
          $display("FAIL flow_c3: count=%0d ready=%b want 3 1", fifo_count_o, ready_o);
        end
        if ((c == 4 || c == 40 || c == 42) && (fifo_count_o !== 3'd4 || ready_o !== 1'b0)) begin
          errors++;
          $display("FAIL flow_full c=%0d: count=%0d ready=%b want 4 0", c, fifo_count_o, ready_o);
        end
        if (c == 41 && (fifo_count_o !== 3'd3 || ready_o !== 1'b1)) begin
          errors++;
          $display("FAIL flow_c41: count=%0d ready=%b want 3 1", fifo_count_o, ready_o);
        end
      end
      if (c == 240) begin
        checks++;
        if (busy_o !== 1'b1 || fifo_count_o !== 3'd0) begin
          errors++;
          $display("FAIL flow_c240: busy=%b count=%0d want 1 0", busy_o, fifo_count_o);
        end
      end
    end
    valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || idx != 6) begin
      errors++;
      $display("FAIL flow_done: busy=%b accepted=%0d want 0 6", busy_o, idx);
    end
  endtask

  task automatic test_reset_midframe();
    data_i = 8'h00; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    // Queue a second byte so the reset also has to discard FIFO contents.
    data_i = 8'hFF; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (17) step();
    checks++;
    if (uart_tx_o !== 1'b0 || fifo_count_o !== 3'd1) begin
      errors++;
      $display("FAIL mid_before: tx=%b count=%0d want 0 1", uart_tx_o, fifo_count_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (uart_tx_o !== 1'b1 || fifo_count_o !== 3'd0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: tx=%b count=%0d ready=%b busy=%b want 1 0 1 0",
               uart_tx_o, fifo_count_o, ready_o, busy_o);
    end
    repeat (2) step();
    rstn_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      checks++;
      if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_after k=%0d: tx=%b busy=%b want 1 0", k, uart_tx_o, busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
